cycle_term_gen: RTL and testbench
=================================

# cycle_term_gen

Parametrised bus-cycle termination generator for the SDMAC register and peripheral ports. It serves NCH independently selected register windows and delays `DSK_` by a per-channel, per-direction wait count latched at cycle start. An optional timeout asserts `BERR_` when no termination arrives. It sits between the CPU bus strobes and the DSACK/BERR drivers.

## Interface
- `NCH`, 4: number of select channels (1..8)
- `CNT_W`, 4: width of each wait-count field
- `TO_CYCLES`, 255: timeout length in `nCPUCLK` rising edges (used only with timeout compiled in)
- `nCPUCLK` in 1: single clock; all state updates on its rising edge
- `RESET_` in 1: asynchronous, active-low reset
- `AS_` in 1: CPU address strobe, active low
- `SEL_` in NCH: channel selects, active low
- `INHIBIT` in NCH: per-channel block; 1 = this block never terminates for that channel
- `RW` in 1: 1 = read, 0 = write
- `WAIT_RD` in NCH*CNT_W: read wait count; channel i uses bits [i*CNT_W +: CNT_W]
- `WAIT_WR` in NCH*CNT_W: write wait count, same packing
- `DSK_` out 1: termination, active low; registered `dsk_q` ORed with `AS_`
- `BERR_` out 1: bus error, active low; registered `berr_q` ORed with `AS_`
- `BUSY` out 1: high in COUNT, TERM or ERR
- `CH` out $clog2(NCH) (minimum 1): latched channel index

## Operation
- States: IDLE, COUNT, TERM, ERR.
- IDLE: accepts a cycle when `AS_`=0, some `SEL_[i]`=0 and `INHIBIT[i]`=0. If several selects are low, the lowest index wins. Inhibit is checked only for the winner. On acceptance: `CH`<=i, `cnt`<=(RW ? WAIT_RD[i] : WAIT_WR[i]), state COUNT.
- COUNT: if `cnt`==0 then `dsk_q`<=0 and state TERM; otherwise `cnt`<=`cnt`-1.
- TERM: holds `dsk_q`=0 until `AS_` is sampled high.
- ERR: holds `berr_q`=0 until `AS_` is sampled high.
- `AS_` sampled high in any state: state IDLE, `dsk_q`<=1, `berr_q`<=1, `cnt`<=0. A cycle aborted in COUNT never terminates.
- Wait counts, `RW` and `SEL_` are ignored after acceptance; the latched values govern the cycle.
- `DSK_` and `BERR_` are never low together. Timeout is inhibited once `dsk_q`=0.
- Reset: state IDLE, `dsk_q`=1, `berr_q`=1, `cnt`=0, `CH`=0, `BUSY`=0, timeout counter 0. Reset has priority over everything, including mid-cycle.

## Timing
- The acceptance edge is E0. `DSK_` falls after edge E(W+1), where W is the latched count. W=0 falls after E1; W=15 falls after E16.
- `DSK_` and `BERR_` rise combinationally as soon as `AS_` rises. Registers clear on the next edge.
- A new cycle needs `AS_` sampled high for at least one edge between cycles. Back-to-back acceptance is then possible on the first edge with `AS_` low again.
- `BUSY` rises after E0 and falls after the first edge that samples `AS_` high.

## Configuration
- `CYCLE_TERM_TIMEOUT_EN` defined:
  - The timeout counter, width $clog2(TO_CYCLES+1), increments on every edge with `AS_`=0 and `dsk_q`=1, in any state.
  - On reaching TO_CYCLES it sets `berr_q`<=0 and moves to ERR. This also applies from IDLE with no or inhibited select.
  - The counter saturates and clears when `AS_` is sampled high.
- `CYCLE_TERM_TIMEOUT_EN` not defined: no timeout counter, `berr_q` is constant 1, `BERR_` stays high, and ERR is unreachable.

## Structure
- Package `cycle_term_pkg`: state encoding constants, the `$clog2`-based width helpers for `CH` and the timeout counter, and the IDLE reset value.
- Sub-module `term_sel_enc`: parametrised NCH-input lowest-index-wins priority encoder with `valid` and `index` outputs. Used for `SEL_` arbitration.

## Test plan
- Reset: hold `RESET_`=0 mid-COUNT -> `DSK_`=1, `BERR_`=1, `BUSY`=0, `CH`=0 immediately; cycle not resumed after release.
- Read on channel 2: WAIT_RD[2]=3, `SEL_`=4'b1011, `RW`=1 -> `DSK_` low after E4, `CH`=2. Raise `AS_` -> `DSK_` high the same instant.
- Write on channel 0: WAIT_WR[0]=0, WAIT_RD[0]=7, `RW`=0 -> `DSK_` low after E1. Change WAIT_WR mid-cycle -> no effect.
- Priority and inhibit: `SEL_`=4'b0101 -> `CH`=1. Same with INHIBIT[1]=1 -> no acceptance and `DSK_` stays high.
- Abort: WAIT=10, `AS_` raised after E5 -> `DSK_` never falls. Next cycle with W=2 -> `DSK_` low after its E3.
- Timeout (macro on, TO_CYCLES=8): `AS_`=0 with no select -> `BERR_` low after edge 8 and `DSK_` stays high. With W=15 and TO_CYCLES=8 -> `BERR_` wins and `DSK_` never falls.

Source files
------------

// File: rtl/cycle_term_pkg.sv
// Shared types and width helpers for the bus-cycle termination generator.
package cycle_term_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_TERM  = 2'd2,
        ST_ERR   = 2'd3
    } term_state_t;

    localparam term_state_t ST_RESET = ST_IDLE;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int to_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/term_sel_enc.sv
// Lowest-index-wins priority encoder over active-high requests.
module term_sel_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cycle_term_gen.sv
// Bus-cycle termination generator: per-channel wait counts delay DSK_.
// Optional bus-error timeout is compiled in with CYCLE_TERM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for AS_ low with an uninhibited select
// COUNT | latched wait count running down
// TERM  | DSK_ asserted until AS_ rises
// ERR   | BERR_ asserted until AS_ rises (timeout only)
module cycle_term_gen
    import cycle_term_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CNT_W     = 4,
    parameter int TO_CYCLES = 255
) (
    input  logic                     nCPUCLK,
    input  logic                     RESET_,
    input  logic                     AS_,
    input  logic [NCH-1:0]           SEL_,
    input  logic [NCH-1:0]           INHIBIT,
    input  logic                     RW,
    input  logic [NCH*CNT_W-1:0]     WAIT_RD,
    input  logic [NCH*CNT_W-1:0]     WAIT_WR,
    output logic                     DSK_,
    output logic                     BERR_,
    output logic                     BUSY,
    output logic [ch_width(NCH)-1:0] CH
);

    localparam int CH_W = ch_width(NCH);
    localparam int TO_W = to_width(TO_CYCLES);

    term_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             dsk_q, dsk_d;
    logic             berr_q;
    logic             sel_valid;
    logic [CH_W-1:0]  sel_idx;

    term_sel_enc #(
        .N  (NCH),
        .IW (CH_W)
    ) u_sel_enc (
        .req   (~SEL_),
        .valid (sel_valid),
        .index (sel_idx)
    );

`ifdef CYCLE_TERM_TIMEOUT_EN
    logic            berr_d;
    logic [TO_W-1:0] to_q, to_d;
`else
    logic [TO_W-1:0] unused_to_cfg;
    assign unused_to_cfg = TO_W'(TO_CYCLES);
    assign berr_q        = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        dsk_d   = dsk_q;
`ifdef CYCLE_TERM_TIMEOUT_EN
        berr_d  = berr_q;
        to_d    = to_q;
`endif
        if (AS_) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dsk_d   = 1'b1;
`ifdef CYCLE_TERM_TIMEOUT_EN
            berr_d  = 1'b1;
            to_d    = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_valid && !INHIBIT[sel_idx]) begin
                        ch_d    = sel_idx;
                        cnt_d   = RW ? WAIT_RD[int'(sel_idx)*CNT_W +: CNT_W]
                                     : WAIT_WR[int'(sel_idx)*CNT_W +: CNT_W];
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (cnt_q == '0) begin
                        dsk_d   = 1'b0;
                        state_d = ST_TERM;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_TERM, ST_ERR: begin
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef CYCLE_TERM_TIMEOUT_EN
            // A termination landing on the same edge as the timeout wins.
            if (dsk_q) begin
                if (to_q != TO_W'(TO_CYCLES))
                    to_d = to_q + TO_W'(1);
                if (to_q == TO_W'(TO_CYCLES - 1) && dsk_d) begin
                    berr_d  = 1'b0;
                    state_d = ST_ERR;
                end
            end
`endif
        end
    end

    always_ff @(posedge nCPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            ch_q    <= '0;
            dsk_q   <= 1'b1;
`ifdef CYCLE_TERM_TIMEOUT_EN
            berr_q  <= 1'b1;
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            dsk_q   <= dsk_d;
`ifdef CYCLE_TERM_TIMEOUT_EN
            berr_q  <= berr_d;
            to_q    <= to_d;
`endif
        end
    end

    assign DSK_  = dsk_q | AS_;
    assign BERR_ = berr_q | AS_;
    assign BUSY  = (state_q != ST_IDLE);
    assign CH    = ch_q;

endmodule

// File: tb/tb_cycle_term_gen.sv
// Self-checking bench for cycle_term_gen with an edge-counting reference model.
module tb_cycle_term_gen;

    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int TO  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              as_n;
    logic [NCH-1:0]    sel_n;
    logic [NCH-1:0]    inhibit;
    logic              rw;
    logic [NCH*CW-1:0] wait_rd;
    logic [NCH*CW-1:0] wait_wr;
    logic              dsk_n;
    logic              berr_n;
    logic              busy;
    logic [1:0]        ch;

    int n_checks = 0;
    int n_errors = 0;

    cycle_term_gen #(
        .NCH       (NCH),
        .CNT_W     (CW),
        .TO_CYCLES (TO)
    ) dut (
        .nCPUCLK (clk),
        .RESET_  (rst_n),
        .AS_     (as_n),
        .SEL_    (sel_n),
        .INHIBIT (inhibit),
        .RW      (rw),
        .WAIT_RD (wait_rd),
        .WAIT_WR (wait_wr),
        .DSK_    (dsk_n),
        .BERR_   (berr_n),
        .BUSY    (busy),
        .CH      (ch)
    );

    always #5 clk = ~clk;

    // Model: acceptance edge index is 0; DSK_ falls once W+1 edges have elapsed.
    logic m_active, m_done, m_err;
    int   m_ch, m_since, m_w, m_to;
    logic n_active, n_done, n_err;
    int   n_ch, n_since, n_w, n_to, win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_ch <= 0; m_since <= 0; m_w <= 0; m_to <= 0;
        end else if (as_n) begin
            m_active <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_since <= 0; m_to <= 0;
        end else begin
            n_active = m_active; n_done = m_done; n_err = m_err;
            n_ch = m_ch; n_since = m_since; n_w = m_w; n_to = m_to;
            if (!m_active && !m_err) begin
                win = -1;
                for (int i = NCH - 1; i >= 0; i--)
                    if (!sel_n[i]) win = i;
                if (win >= 0 && !inhibit[win]) begin
                    n_active = 1'b1;
                    n_ch     = win;
                    n_w      = rw ? int'(wait_rd[win*CW +: CW]) : int'(wait_wr[win*CW +: CW]);
                    n_since  = 0;
                end
            end else if (m_active && !m_done && !m_err) begin
                n_since = m_since + 1;
                if (n_since == m_w + 1) n_done = 1'b1;
            end
`ifdef CYCLE_TERM_TIMEOUT_EN
            if (!m_done) begin
                if (m_to < TO) n_to = m_to + 1;
                if (m_to < TO && n_to == TO && !n_done) n_err = 1'b1;
            end
`endif
            m_active <= n_active; m_done <= n_done; m_err <= n_err;
            m_ch <= n_ch; m_since <= n_since; m_w <= n_w; m_to <= n_to;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (dsk_n !== (m_done ? as_n : 1'b1) || berr_n !== (m_err ? as_n : 1'b1) ||
                busy !== (m_active || m_err) || int'(ch) != m_ch) begin
                n_errors++;
                $display("FAIL model t=%0t dsk=%b/%b berr=%b/%b busy=%b/%b ch=%0d/%0d",
                         $time, dsk_n, (m_done ? as_n : 1'b1), berr_n, (m_err ? as_n : 1'b1),
                         busy, (m_active || m_err), ch, m_ch);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic end_cycle();
        as_n  = 1'b1;
        sel_n = '1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; as_n = 1'b1; sel_n = '1; inhibit = '0; rw = 1'b1;
        wait_rd = '0; wait_wr = '0;
        step(2);
        chk("reset_dsk", dsk_n, 1);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Read on channel 2, W=3
        wait_rd[2*CW +: CW] = 4'd3;
        rw = 1'b1; sel_n = 4'b1011; as_n = 1'b0;
        step();
        chk("rd2_busy_e0", busy, 1);
        chk("rd2_ch", ch, 2);
        chk("rd2_dsk_e0", dsk_n, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rd2_dsk_ek", dsk_n, (k == 4) ? 0 : 1);
        end
        as_n = 1'b1;
        #1;
        chk("rd2_dsk_comb_rise", dsk_n, 1);
        step();
        chk("rd2_busy_after", busy, 0);

        // Write on channel 0, W=0, RD count 7 ignored; wait count change ignored
        wait_wr[0 +: CW] = 4'd0; wait_rd[0 +: CW] = 4'd7;
        rw = 1'b0; sel_n = 4'b1110; as_n = 1'b0;
        step();
        chk("wr0_dsk_e0", dsk_n, 1);
        wait_wr[0 +: CW] = 4'd9; rw = 1'b1;
        step();
        chk("wr0_dsk_e1", dsk_n, 0);
        chk("wr0_ch", ch, 0);
        end_cycle();

        // Priority: channels 1 and 3 selected -> 1 wins
        wait_rd[1*CW +: CW] = 4'd1;
        rw = 1'b1; sel_n = 4'b0101; as_n = 1'b0;
        step();
        chk("prio_ch", ch, 1);
        step(2);
        chk("prio_dsk_e2", dsk_n, 0);
        end_cycle();

        // Same with channel 1 inhibited: no acceptance
        inhibit = 4'b0010;
        sel_n = 4'b0101; as_n = 1'b0;
        step(4);
        chk("inh_busy", busy, 0);
        chk("inh_dsk", dsk_n, 1);
        end_cycle();
        inhibit = '0;

        // Abort a W=10 cycle after E5, then back-to-back W=2
        wait_rd[0 +: CW] = 4'd10;
        rw = 1'b1; sel_n = 4'b1110; as_n = 1'b0;
        step(6);
        chk("abort_dsk_e5", dsk_n, 1);
        as_n = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        wait_rd[0 +: CW] = 4'd2;
        as_n = 1'b0;
        step();
        chk("b2b_busy_e0", busy, 1);
        step(2);
        chk("b2b_dsk_e2", dsk_n, 1);
        step();
        chk("b2b_dsk_e3", dsk_n, 0);
        end_cycle();

        // Reset mid-COUNT on channel 3
        wait_rd[3*CW +: CW] = 4'd10;
        sel_n = 4'b0111; as_n = 1'b0;
        step(3);
        chk("rst_pre_ch", ch, 3);
        rst_n = 1'b0;
        sel_n = '1;
        #1;
        chk("rst_dsk", dsk_n, 1);
        chk("rst_berr", berr_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ch", ch, 0);
        step();
        rst_n = 1'b1;
        step(5);
        chk("rst_no_resume_busy", busy, 0);
        chk("rst_no_resume_dsk", dsk_n, 1);
        end_cycle();

`ifdef CYCLE_TERM_TIMEOUT_EN
        // Timeout with no select: BERR_ low after the 8th edge with AS_ low
        as_n = 1'b0; sel_n = '1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("to_idle_berr", berr_n, (k >= 8) ? 0 : 1);
            chk("to_idle_dsk", dsk_n, 1);
        end
        as_n = 1'b1;
        #1;
        chk("to_berr_comb_rise", berr_n, 1);
        step();

        // Timeout beats W=15; acceptance edge is the first counted edge
        wait_rd[0 +: CW] = 4'd15;
        rw = 1'b1; sel_n = 4'b1110; as_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("to_w15_berr", berr_n, (k >= 8) ? 0 : 1);
            chk("to_w15_dsk", dsk_n, 1);
        end
        end_cycle();
`else
        as_n = 1'b0; sel_n = '1;
        step(12);
        chk("noto_berr", berr_n, 1);
        chk("noto_busy", busy, 0);
        end_cycle();
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
